// File: rtl/m92_pixel_mixer_pkg.sv
// Shared sizes, types and helpers for the M92 final video stage.
// Palette word layout: [4:0] red, [9:5] green, [14:10] blue, [15] unused by video.
package m92_video_pkg;

    localparam int PAL_AW = 12;
    localparam int PAL_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        DONE = 2'd2
    } cpu_st_t;

    typedef struct packed {
        logic hb;
        logic vb;
        logic hs;
        logic vs;
    } vtiming_t;

    // Blanked, no sync: what the timing outputs show out of reset.
    localparam vtiming_t VT_RESET = '{hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};

    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

endpackage

// File: rtl/m92_pixel_mixer_if.sv
// CPU-side palette access bus of the pixel mixer.
// master = CPU/bus side, slave = the mixer.
interface m92_pixel_mixer_if;
    import m92_video_pkg::*;

    logic              pal_cs;
    logic              mem_rd;
    logic              mem_wr;
    logic [10:0]       cpu_addr;
    logic [PAL_DW-1:0] cpu_din;
    logic [PAL_DW-1:0] cpu_dout;
    logic              busy;

    modport master (
        output pal_cs, mem_rd, mem_wr, cpu_addr, cpu_din,
        input  cpu_dout, busy
    );

    modport slave (
        input  pal_cs, mem_rd, mem_wr, cpu_addr, cpu_din,
        output cpu_dout, busy
    );

endinterface

// File: rtl/m92_palette_ram.sv
// Single-port 4096x16 palette RAM, registered read, write-first.
// Output register only updates on enabled cycles so a result holds until consumed.
module m92_palette_ram
    import m92_video_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [PAL_AW-1:0] addr,
    input  logic [PAL_DW-1:0] din,
    output logic [PAL_DW-1:0] dout
);

    logic [PAL_DW-1:0] mem [0:(1<<PAL_AW)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout      <= din;
            end else begin
                dout      <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/m92_pixel_mixer.sv
// Tile/sprite priority mix, palette lookup and RGB output with matched sync delay.
// CPU palette accesses are slotted into clocks where ce is low.
//
// CPU FSM states
//   state | meaning
//   IDLE  | no access; a qualified strobe latches addr/data/we
//   PEND  | access latched; issued to RAM on first clk with ce low
//   DONE  | RAM result valid; reads capture it into cpu_dout
module m92_pixel_mixer
    import m92_video_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              pal_bank,
    input  logic [10:0]       tile_color,
    input  logic              tile_prio,
    input  logic [10:0]       spr_color,
    input  logic              spr_prio,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    m92_pixel_mixer_if.slave  cpu,
    output logic [7:0]        red,
    output logic [7:0]        green,
    output logic [7:0]        blue,
    output logic              hblank_out,
    output logic              vblank_out,
    output logic              hsync_out,
    output logic              vsync_out
);

    cpu_st_t           state_q, state_d;
    logic [10:0]       cpu_addr_q;
    logic [PAL_DW-1:0] cpu_din_q;
    logic              cpu_we_q;
    logic [PAL_DW-1:0] cpu_dout_q;
    logic              strobe;
    logic              cpu_issue;

    logic              ram_en;
    logic              ram_we;
    logic [PAL_AW-1:0] ram_addr;
    logic [PAL_DW-1:0] ram_din;
    logic [PAL_DW-1:0] ram_q;

    logic              spr_sel;
    logic [PAL_AW-1:0] vaddr_d, vaddr_q;
    logic              vid_rd_q;
    logic [14:0]       vid_word_q;
    vtiming_t          vt_in, vt1_q, vt2_q, vt3_q;
    logic [7:0]        red_q, green_q, blue_q;

    // Colour bit 10 carries no palette information at this stage.
    logic              unused_color_msb;
    assign unused_color_msb = tile_color[10] ^ spr_color[10];

    // ---------------- CPU access FSM ----------------
    assign strobe = cpu.pal_cs & (cpu.mem_rd | cpu.mem_wr);

    always_comb begin
        state_d   = state_q;
        cpu_issue = 1'b0;
        case (state_q)
            IDLE: begin
                if (strobe) state_d = PEND;
            end
            PEND: begin
                if (!ce) begin
                    cpu_issue = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cpu_addr_q <= '0;
            cpu_din_q  <= '0;
            cpu_we_q   <= 1'b0;
            cpu_dout_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && strobe) begin
                cpu_addr_q <= cpu.cpu_addr;
                cpu_din_q  <= cpu.cpu_din;
                cpu_we_q   <= cpu.mem_wr;
            end
            // DONE is entered right after the CPU slot, so ram_q is still the CPU result.
            if (state_q == DONE && !cpu_we_q) begin
                cpu_dout_q <= ram_q;
            end
        end
    end

    assign cpu.busy     = (state_q != IDLE);
    assign cpu.cpu_dout = cpu_dout_q;

    // ---------------- palette RAM port sharing ----------------
    always_comb begin
        ram_en   = ce | cpu_issue;
        ram_we   = cpu_issue & cpu_we_q;
        ram_addr = ce ? vaddr_q : {pal_bank, cpu_addr_q};
        ram_din  = cpu_din_q;
    end

    m92_palette_ram u_ram (
        .clk  (clk),
        .en   (ram_en),
        .we   (ram_we),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_q)
    );

    // ---------------- video pipeline ----------------
    always_comb begin
        spr_sel = (spr_color[3:0] != 4'h0) && (!tile_prio || spr_prio);
        vaddr_d = spr_sel ? {pal_bank, 1'b1, spr_color[9:0]}
                          : {pal_bank, 1'b0, tile_color[9:0]};
    end

    assign vt_in = '{hb: hblank_in, vb: vblank_in, hs: hsync_in, vs: vsync_in};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vaddr_q    <= '0;
            vid_rd_q   <= 1'b0;
            vid_word_q <= '0;
            vt1_q      <= VT_RESET;
            vt2_q      <= VT_RESET;
            vt3_q      <= VT_RESET;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
        end else begin
            vid_rd_q <= ce;
            // A CPU slot may reuse the RAM before the next ce, so park the video word here.
            if (vid_rd_q) begin
                vid_word_q <= ram_q[14:0];
            end
            if (ce) begin
                vaddr_q <= vaddr_d;
                vt1_q   <= vt_in;
                vt2_q   <= vt1_q;
                vt3_q   <= vt2_q;
                if (vt2_q.hb || vt2_q.vb) begin
                    red_q   <= '0;
                    green_q <= '0;
                    blue_q  <= '0;
                end else begin
                    red_q   <= expand5(vid_word_q[4:0]);
                    green_q <= expand5(vid_word_q[9:5]);
                    blue_q  <= expand5(vid_word_q[14:10]);
                end
            end
        end
    end

    assign red        = red_q;
    assign green      = green_q;
    assign blue       = blue_q;
    assign hblank_out = vt3_q.hb;
    assign vblank_out = vt3_q.vb;
    assign hsync_out  = vt3_q.hs;
    assign vsync_out  = vt3_q.vs;

endmodule
